// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state encoding for the timer arbiter
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin pick, searching upward from last+1
module rr_select #(
  parameter int M = 4,
  parameter int W = 2
) (
  input  logic [M-1:0] req,
  input  logic [W-1:0] last,
  output logic [M-1:0] sel,
  output logic         valid
);
  // descending scan so the nearest index after last overwrites farther ones
  always_comb begin
    sel = '0;
    for (int k = M; k >= 1; k--)
      if (req[(int'(last) + k) % M]) sel = M'(1) << ((int'(last) + k) % M);
  end
  assign valid = |req;
endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin grant of a shared tick timer with done pulse
module timer_arbiter
  import timer_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [M-1:0]   req,
  input  logic [M*N-1:0] ticks,
  output logic [M-1:0]   grant,
  output logic [M-1:0]   done,
  output logic           busy
);
  localparam int W = M > 1 ? $clog2(M) : 1;
  state_t state, state_n;
  logic [N-1:0] count, tl, tl_eff;
  logic [W-1:0] last, win, sel_idx;
  logic [M-1:0] sel;
  logic sel_v, abort, expire;
  rr_select #(.M(M), .W(W)) u_rr (.req(req), .last(last), .sel(sel), .valid(sel_v));
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < M; i++) if (sel[i]) sel_idx = W'(i);
  end
  assign tl_eff = tl == '0 ? N'(1) : tl;
  assign abort  = !req[win];
  assign expire = ena && count >= tl_eff - N'(1);
  assign busy   = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = sel_v ? RUN : IDLE;
      RUN:     state_n = abort ? IDLE : expire ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      count <= '0;
      tl    <= '0;
      win   <= '0;
      last  <= W'(M - 1);
    end else begin
      state <= state_n;
      done  <= '0;
      if (state == IDLE && sel_v) begin
        win   <= sel_idx;
        tl    <= ticks[int'(sel_idx)*N +: N];
        count <= '0;
        grant <= sel;
      end else if (state == RUN) begin
        if (abort || expire) begin
          grant <= '0;
          last  <= win;
          done  <= abort ? '0 : M'(1) << win;
        end else if (ena) count <= count + N'(1);
      end
    end
  end
endmodule
